// File: rtl/video_capture_pkg.sv
// video_capture_pkg: shared constants, FIFO entry type and CRC helper for the
// video capture stage.
package video_capture_pkg;

    localparam int unsigned VIS_W          = 512;
    localparam int unsigned VIS_H          = 342;
    localparam int unsigned BYTES_PER_LINE = 64;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One captured byte tagged with its raster position.
    typedef struct packed {
        logic [7:0] data;
        logic [5:0] x;
        logic [8:0] y;
    } vc_entry_t;

    // CRC-16-CCITT over one byte, MSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/video_capture_fifo.sv
// vc_fifo: synchronous FIFO of vc_entry_t with first-word-fall-through read.
// Ports: clk, reset_n (async active-low), push/wdata, pop/rdata_c,
//        full_c/empty_c status flags. A push while full is accepted only when
//        a pop happens in the same cycle. DEPTH must be a power of two >= 2.
module vc_fifo
    import video_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  vc_entry_t wdata,
    input  logic      pop,
    output vc_entry_t rdata_c,
    output logic      full_c,
    output logic      empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    vc_entry_t   mem [DEPTH];
    logic        wr_en_c;
    logic        rd_en_c;

    // Extra pointer bit distinguishes full from empty.
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign rd_en_c = pop && !empty_c;
    assign wr_en_c = push && (!full_c || rd_en_c);
    assign rdata_c = mem[rd_ptr[AW-1:0]];

    // Storage array needs no reset; pointers define validity.
    always_ff @(posedge clk) begin : mem_write
        if (wr_en_c) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin : ptr_regs
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en_c) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/video_capture.sv
// video_capture: recovers pixel/line position from Mac video syncs, packs the
// visible 512x342 1-bpp raster into bytes (MSB = leftmost pixel), buffers them
// and presents them over valid/ready tagged with byte column and line.
// Ports: clk, reset_n (async active-low); hs_n, vs_n, pix video inputs;
//        byte_data/byte_x/byte_y/byte_valid with byte_ready handshake;
//        frame_start pulse, frame_count, sticky overflow.
// Optional macro VIDCAP_CRC_EN adds frame_crc/crc_valid: CRC-16-CCITT over
// every captured byte of a frame, published on capture of byte (63, 341).
module video_capture
    import video_capture_pkg::*;
#(
    parameter int unsigned PIX_DIV      = 2,
    parameter int unsigned SAMPLE_PHASE = 0,
    parameter int unsigned H_START      = 0,
    parameter int unsigned V_START      = 1,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hs_n,
    input  logic        vs_n,
    input  logic        pix,
    output logic [7:0]  byte_data,
    output logic [5:0]  byte_x,
    output logic [8:0]  byte_y,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic        overflow
`ifdef VIDCAP_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic        crc_valid
`endif
);

    localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned X_W   = $clog2(BYTES_PER_LINE);

    logic             hs_q;
    logic             vs_q;
    logic             hs_fall_c;
    logic             vs_fall_c;
    logic [9:0]       lc;
    logic [9:0]       h;
    logic [DIV_W-1:0] div;
    logic             tick_c;
    logic [10:0]      h_off_c;
    logic [10:0]      v_off_c;
    logic             in_win_c;
    logic             shift_c;
    logic             last_c;
    logic [X_W-1:0]   x_c;
    logic [8:0]       y_c;
    logic [6:0]       sr;
    logic [2:0]       cnt;
    logic             push_q;
    vc_entry_t        push_entry;
    vc_entry_t        fifo_rdata_c;
    logic             fifo_full_c;
    logic             fifo_empty_c;
    logic             pop_c;

    // Sync edge detection: previous registered value high, current input low.
    always_ff @(posedge clk or negedge reset_n) begin : sync_regs
        if (!reset_n) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            hs_q <= hs_n;
            vs_q <= vs_n;
        end
    end

    assign hs_fall_c = hs_q && !hs_n;
    assign vs_fall_c = vs_q && !vs_n;

    // Line counter; reset value keeps capture off until the first vsync.
    always_ff @(posedge clk or negedge reset_n) begin : line_counter
        if (!reset_n) begin
            lc <= 10'h3FF;
        end else if (vs_fall_c && hs_fall_c) begin
            lc <= 10'd1;
        end else if (vs_fall_c) begin
            lc <= 10'd0;
        end else if (hs_fall_c && lc != 10'h3FF) begin
            lc <= lc + 10'd1;
        end
    end

    assign tick_c = (div == DIV_W'(SAMPLE_PHASE));

    // Pixel divider and saturating pixel counter, both restarted by hsync.
    always_ff @(posedge clk or negedge reset_n) begin : pixel_counter
        if (!reset_n) begin
            div <= '0;
            h   <= 10'h3FF;
        end else if (hs_fall_c) begin
            div <= '0;
            h   <= 10'd0;
        end else begin
            div <= (div == DIV_W'(PIX_DIV - 1)) ? '0 : div + DIV_W'(1);
            if (tick_c && h != 10'h3FF) begin
                h <= h + 10'd1;
            end
        end
    end

    // Offsets wrap to large values before the window start, so one compare each.
    assign h_off_c  = {1'b0, h} - 11'(H_START);
    assign v_off_c  = {1'b0, lc} - 11'(V_START);
    assign in_win_c = (h_off_c < 11'(VIS_W)) && (v_off_c < 11'(VIS_H));
    assign shift_c  = tick_c && in_win_c && !hs_fall_c && !vs_fall_c;
    assign last_c   = shift_c && (cnt == 3'd7);
    assign x_c      = X_W'(h_off_c >> 3);
    assign y_c      = 9'(v_off_c);

    // Shift register and registered FIFO write request.
    always_ff @(posedge clk or negedge reset_n) begin : capture
        if (!reset_n) begin
            sr         <= '0;
            cnt        <= '0;
            push_q     <= 1'b0;
            push_entry <= '0;
        end else begin
            if (hs_fall_c || vs_fall_c) begin
                cnt <= '0;
            end else if (shift_c) begin
                sr  <= {sr[5:0], pix};
                cnt <= cnt + 3'd1;
            end
            push_q <= last_c;
            if (last_c) begin
                push_entry.data <= {sr, pix};
                push_entry.x    <= x_c;
                push_entry.y    <= y_c;
            end
        end
    end

    vc_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_q),
        .wdata   (push_entry),
        .pop     (pop_c),
        .rdata_c (fifo_rdata_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c)
    );

    assign pop_c = !fifo_empty_c && (!byte_valid || byte_ready);

    // Output register and sticky drop flag.
    always_ff @(posedge clk or negedge reset_n) begin : out_reg
        if (!reset_n) begin
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_x     <= '0;
            byte_y     <= '0;
            overflow   <= 1'b0;
        end else begin
            if (pop_c) begin
                byte_valid <= 1'b1;
                byte_data  <= fifo_rdata_c.data;
                byte_x     <= fifo_rdata_c.x;
                byte_y     <= fifo_rdata_c.y;
            end else if (byte_ready) begin
                byte_valid <= 1'b0;
            end
            if (push_q && fifo_full_c && !pop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    // Frame start pulse and counter.
    always_ff @(posedge clk or negedge reset_n) begin : frame_regs
        if (!reset_n) begin
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_start <= vs_fall_c;
            if (vs_fall_c) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

`ifdef VIDCAP_CRC_EN
    logic [15:0] crc_acc;
    logic [15:0] crc_next_c;

    assign crc_next_c = crc16_byte(crc_acc, {sr, pix});

    // Running CRC over captured bytes, published at the last visible byte.
    always_ff @(posedge clk or negedge reset_n) begin : crc_regs
        if (!reset_n) begin
            crc_acc   <= CRC_INIT;
            frame_crc <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            if (vs_fall_c) begin
                crc_acc <= CRC_INIT;
            end else if (last_c) begin
                crc_acc <= crc_next_c;
                if (x_c == X_W'(BYTES_PER_LINE - 1) && y_c == 9'(VIS_H - 1)) begin
                    frame_crc <= crc_next_c;
                    crc_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule
